// File: rtl/posit_pkg.sv
// Shared constants and helpers for the posit datapath.
package posit_pkg;

  localparam int unsigned PositN  = 32;
  localparam int unsigned PositEs = 2;

  localparam logic [PositN-1:0] PositNar = 32'h8000_0000;
  localparam logic [PositN-1:0] IntMax   = 32'h7FFF_FFFF;
  localparam logic [PositN-1:0] IntMin   = 32'h8000_0000;

  // Signed width that holds k*2^es + e for every regime length.
  function automatic int unsigned scale_width(int unsigned n, int unsigned es);
    return $clog2(n) + es + 2;
  endfunction

endpackage

// File: rtl/posit_to_int_lod.sv
// Leading-one detector: counts leading zeros of i_vec (W when the vector is all zero).
module posit_to_int_lod #(
  parameter int unsigned W   = 31,
  parameter int unsigned LzW = $clog2(W + 1)
) (
  input  logic [W-1:0]   i_vec,
  output logic [LzW-1:0] o_lz
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    o_lz = LzW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (i_vec[i]) o_lz = LzW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/posit_to_int.sv
// Three-stage posit to signed-integer converter, round-to-nearest-even with saturation.
module posit_to_int
  import posit_pkg::*;
#(
  parameter int unsigned N  = PositN,
  parameter int unsigned ES = PositEs
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_posit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_int,
  output logic         out_nar,
  output logic         out_ovf
);

  localparam int unsigned SW  = scale_width(N, ES);
  localparam int unsigned LzW = $clog2(N);
  localparam int unsigned BW  = N - 1;
  localparam int unsigned FW  = BW - ES;
  localparam int unsigned MW  = FW + 1;
  localparam int unsigned XW  = MW + N;

  localparam logic [N-1:0]          LIntMax = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]          LIntMin = {1'b1, {(N-1){1'b0}}};
  localparam logic [N:0]            Half    = {2'b01, {(N-1){1'b0}}};
  localparam logic [BW-1:0]         BodyOne = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [LzW:0]          ShOne   = {{LzW{1'b0}}, 1'b1};
  localparam logic [LzW-1:0]        SclOne  = {{(LzW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0]  ScOne   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0]  ScLo    = '1;
  localparam logic signed [SW-1:0]  ScHi    = SW'(N - 2);
  localparam logic signed [SW-1:0]  ScTop   = SW'(N - 1);

  logic w_adv;
  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv & !rst;

  // S1: sign, absolute body, regime run length
  logic          w_sign, w_r0;
  logic [BW-1:0] w_body, w_lod_in;
  logic [LzW-1:0] w_lz;

  assign w_sign   = in_posit[N-1];
  assign w_body   = w_sign ? (~in_posit[N-2:0] + BodyOne) : in_posit[N-2:0];
  assign w_r0     = w_body[BW-1];
  assign w_lod_in = w_r0 ? ~w_body : w_body;

  posit_to_int_lod #(
    .W   (BW),
    .LzW (LzW)
  ) u_lod (
    .i_vec (w_lod_in),
    .o_lz  (w_lz)
  );

  logic           r1_valid, r1_sign, r1_zero, r1_nar, r1_r0;
  logic [LzW-1:0] r1_lz;
  logic [BW-1:0]  r1_body;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_zero  <= 1'b0;
      r1_nar   <= 1'b0;
      r1_r0    <= 1'b0;
      r1_lz    <= '0;
      r1_body  <= '0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r1_sign  <= w_sign;
      r1_zero  <= (in_posit == '0);
      r1_nar   <= (in_posit == LIntMin);
      r1_r0    <= w_r0;
      r1_lz    <= w_lz;
      r1_body  <= w_body;
    end
  end

  // S2: scale and left-aligned mantissa
  logic [LzW:0]          w_shamt;
  logic [BW-1:0]         w_rem;
  logic [ES-1:0]         w_e;
  logic signed [SW-1:0]  w_lz_s, w_e_s, w_k, w_scale;

  assign w_shamt = {1'b0, r1_lz} + ShOne;
  assign w_rem   = r1_body << w_shamt;
  assign w_e     = w_rem[BW-1 -: ES];
  assign w_lz_s  = {{(SW-LzW){1'b0}}, r1_lz};
  assign w_e_s   = {{(SW-ES){1'b0}}, w_e};
  assign w_k     = r1_r0 ? (w_lz_s - ScOne) : (-w_lz_s);
  assign w_scale = (w_k <<< ES) + w_e_s;

  logic                 r2_valid, r2_sign, r2_zero, r2_nar;
  logic signed [SW-1:0] r2_scale;
  logic [MW-1:0]        r2_mant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_zero  <= 1'b0;
      r2_nar   <= 1'b0;
      r2_scale <= '0;
      r2_mant  <= '0;
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_zero  <= r1_zero;
      r2_nar   <= r1_nar;
      r2_scale <= w_scale;
      r2_mant  <= {1'b1, w_rem[FW-1:0]};
    end
  end

  // S3: round, saturate, negate. Shifting by scale+1 keeps scale=-1 on the same path.
  logic           w_in_range, w_big, w_exact, w_guard, w_lsb, w_sticky, w_inc;
  logic [LzW-1:0] w_sh;
  logic [XW-1:0]  w_x;
  logic [N:0]     w_mag;
  logic [N-1:0]   w_int;
  logic           w_nar, w_ovf;

  assign w_in_range = (r2_scale >= ScLo) && (r2_scale <= ScHi);
  assign w_big      = r2_scale > ScHi;
  assign w_exact    = (r2_scale == ScTop) && (r2_mant[FW-1:0] == '0);
  assign w_sh       = r2_scale[LzW-1:0] + SclOne;
  assign w_x        = {{N{1'b0}}, r2_mant} << w_sh;
  assign w_guard    = w_x[FW];
  assign w_lsb      = w_x[FW+1];
  assign w_sticky   = |w_x[FW-1:0];
  assign w_inc      = w_guard & (w_sticky | w_lsb);
  assign w_mag      = w_in_range ? ({1'b0, w_x[XW-1:FW+1]} + {{N{1'b0}}, w_inc}) : '0;

  always_comb begin
    w_int = '0;
    w_nar = 1'b0;
    w_ovf = 1'b0;
    if (r2_nar) begin
      w_int = LIntMin;
      w_nar = 1'b1;
    end else if (r2_zero) begin
      w_int = '0;
    end else if (!r2_sign) begin
      if (w_big || (w_mag >= Half)) begin
        w_int = LIntMax;
        w_ovf = 1'b1;
      end else begin
        w_int = w_mag[N-1:0];
      end
    end else begin
      if ((w_big && !w_exact) || (w_mag > Half)) begin
        w_int = LIntMin;
        w_ovf = 1'b1;
      end else if (w_big || (w_mag == Half)) begin
        w_int = LIntMin;
      end else begin
        w_int = -w_mag[N-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_int   <= '0;
      out_nar   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r2_valid;
      out_int   <= w_int;
      out_nar   <= w_nar;
      out_ovf   <= w_ovf;
    end
  end

endmodule
